// File: rtl/delta_hidden_if.sv
// delta_hidden_if: start/term-stream/result handshake bundle for delta_hidden.
// master = the side feeding terms and taking results, slave = delta_hidden.
interface delta_hidden_if #(
   parameter int DW = 16
);
   logic          start;
   logic [DW-1:0] dadz2_i;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] w_i;
   logic [DW-1:0] delta3_i;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] delta2_o;
   logic          busy;
   logic          sat_o;

   modport master (
      output start, dadz2_i, in_valid, w_i, delta3_i, out_ready,
      input  in_ready, out_valid, delta2_o, busy, sat_o
   );

   modport slave (
      input  start, dadz2_i, in_valid, w_i, delta3_i, out_ready,
      output in_ready, out_valid, delta2_o, busy, sat_o
   );
endinterface

// File: rtl/delta_hidden.sv
// delta_hidden: back-propagated hidden-layer delta,
//   delta2 = (sum_k w_k * delta3_k) * dadz2, rescaled to FW fractional bits.
// Terms stream in over a valid/ready handshake, one result leaves over a
// second handshake. Optional macro DELTA_HIDDEN_SAT_EN: clip the result to
// the DW-bit range and flag it on sat_o; without it the result wraps.
module delta_hidden #(
   parameter int DW  = 16,
   parameter int FW  = 10,
   parameter int N_K = 2
) (
   input logic          clk,
   input logic          res,
   delta_hidden_if.slave bus
);
   localparam int CW = (N_K > 1) ? $clog2(N_K) : 1;
   localparam int AW = 2*DW + $clog2(N_K) + 1;
   localparam int PW = AW + DW;
   localparam logic [CW-1:0] LAST = CW'(N_K - 1);

   typedef enum logic [1:0] {IDLE, ACC, MUL, OUT} state_t;

   state_t                state, state_nx;
   logic [CW-1:0]         cnt_p0;
   logic signed [AW-1:0]  acc_p0;
   logic signed [DW-1:0]  dadz2_p0;
   logic signed [DW-1:0]  delta2_p1;
   logic                  sat_p1;

   // Full-precision w*delta3 product, sign-extended to accumulator width.
   function automatic logic signed [AW-1:0] term_ext(input logic signed [DW-1:0] w,
                                                     input logic signed [DW-1:0] d);
      logic signed [2*DW-1:0] t;
      t = $signed({{DW{w[DW-1]}}, w}) * $signed({{DW{d[DW-1]}}, d});
      return AW'(t);
   endfunction

   // Multiply sum by dadz2, floor-shift by 2*FW, then clip or wrap to DW bits.
   // Returns {clipped, value}.
   function automatic logic [DW:0] scale(input logic signed [AW-1:0] a,
                                         input logic signed [DW-1:0] d);
      logic signed [PW-1:0] p;
      logic signed [PW-1:0] s;
      p = $signed({{DW{a[AW-1]}}, a}) * $signed({{AW{d[DW-1]}}, d});
      s = p >>> (2*FW);
`ifdef DELTA_HIDDEN_SAT_EN
      if (s[PW-1:DW-1] == {(PW-DW+1){s[PW-1]}})
         return {1'b0, s[DW-1:0]};
      else if (s[PW-1])
         return {1'b1, 1'b1, {(DW-1){1'b0}}};
      else
         return {1'b1, 1'b0, {(DW-1){1'b1}}};
`else
      return {1'b0, s[DW-1:0]};
`endif
   endfunction

   // State register.
   always_ff @(posedge clk) begin
      if (!res) state <= IDLE;
      else      state <= state_nx;
   end

   // Next-state and handshake outputs; start is only looked at in IDLE.
   always_comb begin
      state_nx      = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = (state != IDLE);
      case (state)
         IDLE: if (bus.start) state_nx = ACC;
         ACC: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid && (cnt_p0 == LAST)) state_nx = MUL;
         end
         MUL: state_nx = OUT;
         OUT: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Stage 0: capture dadz2 and accumulate terms; stage 1: scale into result.
   always_ff @(posedge clk) begin
      if (!res) begin
         cnt_p0    <= '0;
         acc_p0    <= '0;
         dadz2_p0  <= '0;
         delta2_p1 <= '0;
         sat_p1    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               dadz2_p0 <= $signed(bus.dadz2_i);
               acc_p0   <= '0;
               cnt_p0   <= '0;
            end
            ACC: if (bus.in_valid) begin
               acc_p0 <= acc_p0 + term_ext($signed(bus.w_i), $signed(bus.delta3_i));
               cnt_p0 <= (cnt_p0 == LAST) ? '0 : cnt_p0 + CW'(1);
            end
            MUL: {sat_p1, delta2_p1} <= scale(acc_p0, dadz2_p0);
            default: ;
         endcase
      end
   end

   assign bus.delta2_o = delta2_p1;
   assign bus.sat_o    = sat_p1;
endmodule

// File: tb/tb_delta_hidden.sv
// tb_delta_hidden: directed vector table, hand-written flow-control / reset /
// back-to-back sequences, and randomized operands against an arithmetic model.
module tb_delta_hidden;
   logic clk = 1'b0;
   logic res = 1'b0;
   always #5 clk = ~clk;

   delta_hidden_if #(.DW(16)) bus();
   delta_hidden #(.DW(16), .FW(10), .N_K(2)) dut (.clk(clk), .res(res), .bus(bus));

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] dz, w0, d0, w1, d1;
      logic [15:0] exp_d;
      logic        exp_s;
   } vec_t;

   vec_t tbl[5];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: exact integer sum of products times dadz2, floor-divided by 2^20.
   function automatic logic [16:0] model(input logic [15:0] dz, w0, d0, w1, d1);
      longint s, p, sh;
      s  = longint'($signed(w0)) * longint'($signed(d0))
         + longint'($signed(w1)) * longint'($signed(d1));
      p  = s * longint'($signed(dz));
      sh = p >>> 20;
`ifdef DELTA_HIDDEN_SAT_EN
      if (sh > 64'sd32767)  return {1'b1, 16'h7FFF};
      if (sh < -64'sd32768) return {1'b1, 16'h8000};
`endif
      return {1'b0, sh[15:0]};
   endfunction

   // One full computation; gap = idle cycles before each pair, stall = cycles
   // out_ready stays low, poke = stray start pulses while busy, b2b = start
   // raised together with the result handshake.
   task automatic run_op(input logic [15:0] dz, w0, d0, w1, d1,
                         input int gap, input int stall, input bit poke, input bit b2b,
                         output logic [15:0] rd, output logic rs);
      logic [15:0] ws[2];
      logic [15:0] ds[2];
      logic [15:0] held;
      int n;
      ws[0] = w0; ws[1] = w1; ds[0] = d0; ds[1] = d1;
      n = 0;
      while (bus.busy && n < 20) begin tick; n++; end
      if (n >= 20) chk("idle_timeout", 32'd1, 32'd0);
      bus.start = 1'b1; bus.dadz2_i = dz;
      tick;
      bus.start = 1'b0; bus.dadz2_i = 16'($urandom);
      chk("start_accepted", bus.busy, 1'b1);
      for (int k = 0; k < 2; k++) begin
         for (int g = 0; g < gap; g++) begin
            if (poke) begin bus.start = 1'b1; bus.dadz2_i = 16'($urandom); end
            tick;
            bus.start = 1'b0;
            if (k > 0 || g > 0) chk("no_early_valid", bus.out_valid, 1'b0);
         end
         bus.in_valid = 1'b1; bus.w_i = ws[k]; bus.delta3_i = ds[k];
         n = 0;
         while (!bus.in_ready && n < 20) begin tick; n++; end
         if (n >= 20) chk("in_ready_timeout", 32'd1, 32'd0);
         tick;
         bus.in_valid = 1'b0; bus.w_i = 16'($urandom); bus.delta3_i = 16'($urandom);
      end
      chk("lat_edge1_low", bus.out_valid, 1'b0);
      tick;
      chk("lat_edge2_high", bus.out_valid, 1'b1);
      held = bus.delta2_o;
      rs   = bus.sat_o;
      for (int s = 0; s < stall; s++) begin
         if (poke) begin bus.start = 1'b1; bus.dadz2_i = 16'($urandom); end
         tick;
         bus.start = 1'b0;
         chk("hold_valid", bus.out_valid, 1'b1);
         chk("hold_data", bus.delta2_o, held);
         chk("hold_sat", bus.sat_o, rs);
      end
      bus.out_ready = 1'b1;
      if (b2b) bus.start = 1'b1;
      tick;
      bus.out_ready = 1'b0; bus.start = 1'b0;
      chk("idle_after_handshake", bus.busy, 1'b0);
      rd = held;
   endtask

   logic [15:0] rd;
   logic        rs;
   logic [16:0] m;
   logic [15:0] rv[5];

   initial begin
      tbl[0] = '{16'h0400, 16'h0400, 16'h0400, 16'h0200, 16'h0400, 16'h0600, 1'b0};
      tbl[1] = '{16'h0200, 16'hFC00, 16'h0400, 16'h0000, 16'h0000, 16'hFE00, 1'b0};
`ifdef DELTA_HIDDEN_SAT_EN
      tbl[2] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1};
      tbl[3] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 1'b1};
`else
      tbl[2] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'hE800, 1'b0};
      tbl[3] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h0FFF, 1'b0};
`endif
      tbl[4] = '{16'h0001, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'hFFFF, 1'b0};

      bus.start = 1'b0; bus.dadz2_i = '0; bus.in_valid = 1'b0;
      bus.w_i = '0; bus.delta3_i = '0; bus.out_ready = 1'b0;
      res = 1'b0;
      repeat (3) tick;
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_in_ready", bus.in_ready, 1'b0);
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_delta2", bus.delta2_o, 16'h0000);
      chk("rst_sat", bus.sat_o, 1'b0);
      res = 1'b1;
      tick;

      // Directed vector table.
      for (int i = 0; i < 5; i++) begin
         run_op(tbl[i].dz, tbl[i].w0, tbl[i].d0, tbl[i].w1, tbl[i].d1, 0, 0, 1'b0, 1'b0, rd, rs);
         chk($sformatf("vec%0d_delta2", i), rd, tbl[i].exp_d);
         chk($sformatf("vec%0d_sat", i), rs, tbl[i].exp_s);
      end

      // Flow control: gaps between pairs, stalled output, stray starts.
      run_op(16'h0400, 16'h0400, 16'h0400, 16'h0200, 16'h0400, 3, 5, 1'b1, 1'b0, rd, rs);
      chk("flow_delta2", rd, 16'h0600);
      chk("flow_sat", rs, 1'b0);

      // Reset after the first pair.
      bus.start = 1'b1; bus.dadz2_i = 16'h0400;
      tick;
      bus.start = 1'b0;
      bus.in_valid = 1'b1; bus.w_i = 16'h7FFF; bus.delta3_i = 16'h7FFF;
      tick;
      bus.in_valid = 1'b0;
      res = 1'b0;
      tick;
      res = 1'b1;
      chk("midrst_busy", bus.busy, 1'b0);
      chk("midrst_in_ready", bus.in_ready, 1'b0);
      run_op(16'h0400, 16'h0400, 16'h0400, 16'h0200, 16'h0400, 0, 0, 1'b0, 1'b0, rd, rs);
      chk("after_midrst_delta2", rd, 16'h0600);

      // Reset with a pending result in OUT.
      bus.start = 1'b1; bus.dadz2_i = 16'h0400;
      tick;
      bus.start = 1'b0;
      bus.in_valid = 1'b1; bus.w_i = 16'h0400; bus.delta3_i = 16'h0400;
      tick;
      tick;
      bus.in_valid = 1'b0;
      tick;
      chk("pending_valid", bus.out_valid, 1'b1);
      res = 1'b0;
      tick;
      res = 1'b1;
      chk("outrst_valid", bus.out_valid, 1'b0);
      chk("outrst_busy", bus.busy, 1'b0);
      chk("outrst_delta2", bus.delta2_o, 16'h0000);
      chk("outrst_sat", bus.sat_o, 1'b0);

      // Back-to-back: start with the handshake is ignored, next cycle accepted.
      run_op(16'h0200, 16'hFC00, 16'h0400, 16'h0000, 16'h0000, 0, 2, 1'b0, 1'b1, rd, rs);
      chk("b2b_first", rd, 16'hFE00);
      run_op(16'h0400, 16'h0400, 16'h0400, 16'h0200, 16'h0400, 0, 0, 1'b0, 1'b0, rd, rs);
      chk("b2b_second", rd, 16'h0600);

      // Randomized operands against the model.
      for (int i = 0; i < 30; i++) begin
         for (int j = 0; j < 5; j++) begin
            rv[j] = 16'($urandom);
            if (i[0]) rv[j] = {{4{rv[j][11]}}, rv[j][11:0]};
         end
         m = model(rv[0], rv[1], rv[2], rv[3], rv[4]);
         run_op(rv[0], rv[1], rv[2], rv[3], rv[4],
                int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), rd, rs);
         chk($sformatf("rand%0d_delta2", i), rd, m[15:0]);
         chk($sformatf("rand%0d_sat", i), rs, m[16]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
